// File: rtl/fir_pkg.sv
// Shared constants and types for the FIR sample path.
package fir_pkg;

    localparam int FIR_DATA_W     = 16;
    localparam int FIR_FIFO_DEPTH = 8;

    typedef logic signed [FIR_DATA_W-1:0] sample_t;

    // Pointer width for a power-of-two depth; never narrower than one bit.
    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/fir_fifo_mem.sv
// Sample storage for fir_sample_fifo: one write port and one registered read
// port; the read register resets to zero, the array itself does not.
module fir_fifo_mem
    import fir_pkg::*;
#(
    parameter int DATA_W = FIR_DATA_W,
    parameter int DEPTH  = FIR_FIFO_DEPTH,
    parameter int PTR_W  = ptr_width(DEPTH)
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_wr_en,
    input  logic [PTR_W-1:0]  i_wr_addr,
    input  logic [DATA_W-1:0] i_wr_data,
    input  logic              i_rd_en,
    input  logic [PTR_W-1:0]  i_rd_addr,
    output logic [DATA_W-1:0] o_rd_data
);

    logic [DATA_W-1:0] r_mem [DEPTH];

    // NOTE: the array carries no reset so it maps onto plain storage; only
    // pointers and count define which entries are valid.
    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    // NOTE: non-blocking assignment means a read and write to the same slot
    // on one edge returns the old contents, which the full pass-through needs.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_rd_data <= '0;
        end else if (i_rd_en) begin
            o_rd_data <= r_mem[i_rd_addr];
        end
    end

endmodule

// File: rtl/fir_sample_fifo.sv
// Circular sample buffer between controlUnit and the MAC path.
// Optional sticky overflow/underflow flags: define FIR_FIFO_ERR_EN.
module fir_sample_fifo
    import fir_pkg::*;
#(
    parameter int DATA_W = FIR_DATA_W,
    parameter int DEPTH  = FIR_FIFO_DEPTH
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic                       FIFO_write,
    input  logic                       FIFO_read,
    input  logic [DATA_W-1:0]          din,
    output logic [DATA_W-1:0]          dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
`ifdef FIR_FIFO_ERR_EN
    ,
    output logic                       ovf,
    output logic                       unf
`endif
);

    localparam int PTR_W = ptr_width(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [PTR_W-1:0] r_wp;
    logic [PTR_W-1:0] r_rp;
    logic [CNT_W-1:0] r_count;
    logic             w_wr_ok;
    logic             w_rd_ok;

    assign full  = (r_count == CNT_W'(DEPTH));
    assign empty = (r_count == '0);
    assign count = r_count;

    // Full with a simultaneous read passes the new sample in behind the oldest.
    assign w_wr_ok = FIFO_write && (!full || FIFO_read);
    assign w_rd_ok = FIFO_read && !empty;

    fir_fifo_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .PTR_W  (PTR_W)
    ) u_mem (
        .i_clk     (CLK),
        .i_rst_n   (RST),
        .i_wr_en   (w_wr_ok),
        .i_wr_addr (r_wp),
        .i_wr_data (din),
        .i_rd_en   (w_rd_ok),
        .i_rd_addr (r_rp),
        .o_rd_data (dout)
    );

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_wp    <= '0;
            r_rp    <= '0;
            r_count <= '0;
        end else begin
            if (w_wr_ok) r_wp <= r_wp + 1'b1;
            if (w_rd_ok) r_rp <= r_rp + 1'b1;
            case ({w_wr_ok, w_rd_ok})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

`ifdef FIR_FIFO_ERR_EN
    logic r_ovf;
    logic r_unf;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_ovf <= 1'b0;
            r_unf <= 1'b0;
        end else begin
            if (FIFO_write && full && !FIFO_read) r_ovf <= 1'b1;
            if (FIFO_read && empty)               r_unf <= 1'b1;
        end
    end

    assign ovf = r_ovf;
    assign unf = r_unf;
`endif

endmodule

// File: tb/tb_fir_sample_fifo.sv
// Scoreboard bench for fir_sample_fifo: accepted writes are queued, accepted
// reads pop the oldest expected sample for comparison with dout.
module tb_fir_sample_fifo;
    import fir_pkg::*;

    localparam int DEPTH = FIR_FIFO_DEPTH;

    logic        CLK;
    logic        RST;
    logic        FIFO_write;
    logic        FIFO_read;
    logic [15:0] din;
    logic [15:0] dout;
    logic        full;
    logic        empty;
    logic [3:0]  count;
`ifdef FIR_FIFO_ERR_EN
    logic        ovf;
    logic        unf;
`endif

    int checks = 0;
    int errors = 0;

    sample_t sb[$];
    sample_t m_dout;

    fir_sample_fifo dut (
        .CLK        (CLK),
        .RST        (RST),
        .FIFO_write (FIFO_write),
        .FIFO_read  (FIFO_read),
        .din        (din),
        .dout       (dout),
        .full       (full),
        .empty      (empty),
        .count      (count)
`ifdef FIR_FIFO_ERR_EN
        ,
        .ovf        (ovf),
        .unf        (unf)
`endif
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Drives one cycle of strobes, advances past the edge and updates the model.
    task automatic step(input logic wr, input logic rd, input sample_t d);
        bit w_ok;
        bit r_ok;
        w_ok = wr && (sb.size() < DEPTH || rd);
        r_ok = rd && (sb.size() > 0);
        FIFO_write = wr;
        FIFO_read  = rd;
        din        = d;
        @(posedge CLK);
        #1;
        if (r_ok) m_dout = sb.pop_front();
        if (w_ok) sb.push_back(d);
        FIFO_write = 1'b0;
        FIFO_read  = 1'b0;
    endtask

    task automatic test_reset;
        for (int i = 1; i <= 4; i++) step(1'b1, 1'b0, sample_t'(16'h0040 + i));
        step(1'b0, 1'b1, '0);
        checks++;
        if (dout !== m_dout) begin
            errors++;
            $display("FAIL reset_pre_dout got=%h exp=%h", dout, m_dout);
        end
        #3;
        RST = 1'b0;
        #1;
        sb.delete();
        m_dout = '0;
        checks++;
        if (count !== 4'd0 || empty !== 1'b1 || full !== 1'b0 || dout !== 16'h0000) begin
            errors++;
            $display("FAIL reset_async got count=%0d empty=%b full=%b dout=%h exp 0/1/0/0000",
                     count, empty, full, dout);
        end
        @(posedge CLK);
        #2;
        RST = 1'b1;
        #1;
    endtask

    task automatic test_fill_drain;
        for (int i = 1; i <= 8; i++) step(1'b1, 1'b0, sample_t'(i));
        checks++;
        if (full !== 1'b1 || count !== 4'd8) begin
            errors++;
            $display("FAIL fill_full got full=%b count=%0d exp full=1 count=8", full, count);
        end
        for (int i = 1; i <= 8; i++) begin
            step(1'b0, 1'b1, '0);
            checks++;
            if (dout !== m_dout || dout !== 16'(i)) begin
                errors++;
                $display("FAIL drain_%0d got=%h exp=%h", i, dout, m_dout);
            end
        end
        checks++;
        if (empty !== 1'b1 || count !== 4'd0) begin
            errors++;
            $display("FAIL drain_empty got empty=%b count=%0d exp 1/0", empty, count);
        end
    endtask

    task automatic test_wrap;
        int burst[4] = '{5, 5, 6, 6};
        int base = 0;
        int max_cnt = 0;
        for (int b = 0; b < 4; b++) begin
            for (int i = 0; i < burst[b]; i++) begin
                if (b % 2 == 0) begin
                    step(1'b1, 1'b0, sample_t'(16'h0100 + base + i));
                end else begin
                    step(1'b0, 1'b1, '0);
                    checks++;
                    if (dout !== m_dout) begin
                        errors++;
                        $display("FAIL wrap_rd_b%0d_%0d got=%h exp=%h", b, i, dout, m_dout);
                    end
                end
                if (int'(count) > max_cnt) max_cnt = int'(count);
            end
            if (b % 2 == 0) base += burst[b];
        end
        checks++;
        if (max_cnt > 6 || count !== 4'd0) begin
            errors++;
            $display("FAIL wrap_count got max=%0d final=%0d exp max<=6 final=0", max_cnt, count);
        end
    endtask

    task automatic test_overflow;
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, sample_t'(16'h0200 + i));
        step(1'b1, 1'b0, sample_t'(16'h7FFF));
        checks++;
        if (count !== 4'd8 || full !== 1'b1) begin
            errors++;
            $display("FAIL ovf_count got count=%0d full=%b exp 8/1", count, full);
        end
`ifdef FIR_FIFO_ERR_EN
        checks++;
        if (ovf !== 1'b1) begin
            errors++;
            $display("FAIL ovf_flag got=%b exp=1", ovf);
        end
`endif
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 1'b1, '0);
            checks++;
            if (dout !== m_dout || dout === 16'h7FFF) begin
                errors++;
                $display("FAIL ovf_drain_%0d got=%h exp=%h", i, dout, m_dout);
            end
        end
    endtask

    task automatic test_simul_full;
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, sample_t'(16'h0300 + i));
        step(1'b1, 1'b1, sample_t'(16'h1234));
        checks++;
        if (dout !== 16'h0300 || count !== 4'd8) begin
            errors++;
            $display("FAIL full_pass got dout=%h count=%0d exp 0300/8", dout, count);
        end
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 1'b1, '0);
            checks++;
            if (dout !== m_dout) begin
                errors++;
                $display("FAIL full_drain_%0d got=%h exp=%h", i, dout, m_dout);
            end
        end
        checks++;
        if (dout !== 16'h1234 || empty !== 1'b1) begin
            errors++;
            $display("FAIL full_last got dout=%h empty=%b exp 1234/1", dout, empty);
        end
    endtask

    task automatic test_simul_empty;
        step(1'b1, 1'b1, sample_t'(16'hABCD));
        checks++;
        if (dout !== 16'h1234 || count !== 4'd1) begin
            errors++;
            $display("FAIL empty_pass got dout=%h count=%0d exp 1234/1", dout, count);
        end
`ifdef FIR_FIFO_ERR_EN
        checks++;
        if (unf !== 1'b1) begin
            errors++;
            $display("FAIL unf_flag got=%b exp=1", unf);
        end
`endif
        step(1'b0, 1'b1, '0);
        checks++;
        if (dout !== 16'hABCD || dout !== m_dout || empty !== 1'b1) begin
            errors++;
            $display("FAIL empty_read got dout=%h empty=%b exp abcd/1", dout, empty);
        end
        step(1'b0, 1'b1, '0);
        checks++;
        if (dout !== 16'hABCD || count !== 4'd0) begin
            errors++;
            $display("FAIL empty_hold got dout=%h count=%0d exp abcd/0", dout, count);
        end
    endtask

    initial begin
        RST        = 1'b0;
        FIFO_write = 1'b0;
        FIFO_read  = 1'b0;
        din        = '0;
        m_dout     = '0;
        #1;
        checks++;
        if (count !== 4'd0 || empty !== 1'b1 || full !== 1'b0 || dout !== 16'h0000) begin
            errors++;
            $display("FAIL init_reset got count=%0d empty=%b full=%b dout=%h", count, empty, full, dout);
        end
        #12;
        RST = 1'b1;
        test_reset();
        test_fill_drain();
        test_wrap();
        test_overflow();
        test_simul_full();
        test_simul_empty();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
